// File: rtl/axi_riscv_lrsc_pkg.sv
// Shared types and sizing helpers for the LR/SC reservation table.
package axi_riscv_lrsc_pkg;

   typedef enum logic [1:0] {EVT_NONE, EVT_LR, EVT_SC, EVT_WR} resv_evt_e;

   // Bits needed to hold the values 0..n inclusive.
   function automatic int unsigned cnt_width(int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/axi_riscv_lrsc_resv_entry.sv
// One reservation slot: valid/id/granule plus optional expiry timer
// (enabled by AXI_RISCV_LRSC_RESV_TIMEOUT_EN).
module axi_riscv_lrsc_resv_entry
   import axi_riscv_lrsc_pkg::*;
#(
   parameter int unsigned ID_WIDTH     = 4,
   parameter int unsigned GRAN_WIDTH   = 61,
   parameter int unsigned RESV_TIMEOUT = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  install_i,
   input  logic                  invalidate_i,
   input  logic [ID_WIDTH-1:0]   id_i,
   input  logic [GRAN_WIDTH-1:0] gran_i,
   input  logic [ID_WIDTH-1:0]   sc_id_i,
   input  logic [GRAN_WIDTH-1:0] sc_gran_i,
   input  logic [GRAN_WIDTH-1:0] wr_gran_i,
   output logic                  valid_o,
   output logic                  valid_d_o,
   output logic                  lr_id_hit_o,
   output logic                  sc_id_hit_o,
   output logic                  sc_gran_hit_o,
   output logic                  wr_gran_hit_o
);

   logic                  valid_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [GRAN_WIDTH-1:0] gran_q;
   logic                  expire;

`ifdef AXI_RISCV_LRSC_RESV_TIMEOUT_EN
   localparam int unsigned TW = cnt_width(RESV_TIMEOUT);
   logic [TW-1:0] tmr_q;

   // The entry stays visible during the cycle its timer reads zero.
   assign expire = valid_q && (tmr_q == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)             tmr_q <= '0;
      else if (install_i)      tmr_q <= TW'(RESV_TIMEOUT);
      else if (tmr_q != '0)    tmr_q <= tmr_q - 1'b1;
   end
`else
   logic unused_timeout;
   assign unused_timeout = (RESV_TIMEOUT == 0);
   assign expire         = 1'b0;
`endif

   // Install is the last step of the cycle, so it overrides any invalidation.
   assign valid_d_o = install_i ? 1'b1 : ((invalidate_i || expire) ? 1'b0 : valid_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         id_q    <= '0;
         gran_q  <= '0;
      end else begin
         valid_q <= valid_d_o;
         if (install_i) begin
            id_q   <= id_i;
            gran_q <= gran_i;
         end
      end
   end

   assign valid_o       = valid_q;
   assign lr_id_hit_o   = valid_q && (id_q == id_i);
   assign sc_id_hit_o   = valid_q && (id_q == sc_id_i);
   assign sc_gran_hit_o = valid_q && (gran_q == sc_gran_i);
   assign wr_gran_hit_o = valid_q && (gran_q == wr_gran_i);

endmodule

// File: rtl/axi_riscv_lrsc_resv_table.sv
// Multi-entry LR/SC reservation table with SC resolution and write snooping.
// Optional per-entry expiry: define AXI_RISCV_LRSC_RESV_TIMEOUT_EN.
module axi_riscv_lrsc_resv_table
   import axi_riscv_lrsc_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH   = 64,
   parameter logic [ADDR_WIDTH-1:0]  ADDR_BEGIN   = '0,
   parameter logic [ADDR_WIDTH-1:0]  ADDR_END     = '0,
   parameter int unsigned            ID_WIDTH     = 4,
   parameter int unsigned            ADDR_LSB     = 3,
   parameter int unsigned            NUM_RESV     = 4,
   parameter int unsigned            RESV_TIMEOUT = 1024
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              lr_valid_i,
   input  logic [ID_WIDTH-1:0]               lr_id_i,
   input  logic [ADDR_WIDTH-1:0]             lr_addr_i,
   input  logic                              sc_valid_i,
   output logic                              sc_ready_o,
   input  logic [ID_WIDTH-1:0]               sc_id_i,
   input  logic [ADDR_WIDTH-1:0]             sc_addr_i,
   output logic                              sc_resp_valid_o,
   input  logic                              sc_resp_ready_i,
   output logic                              sc_resp_ok_o,
   output logic [ID_WIDTH-1:0]               sc_resp_id_o,
   input  logic                              wr_valid_i,
   input  logic [ADDR_WIDTH-1:0]             wr_addr_i,
   output logic [cnt_width(NUM_RESV)-1:0]    occupancy_o
);

   localparam int unsigned GW = ADDR_WIDTH - ADDR_LSB;
   localparam int unsigned OW = cnt_width(NUM_RESV);
   localparam int unsigned VW = (NUM_RESV > 1) ? $clog2(NUM_RESV) : 1;

   // Wrapping subtraction folds the closed-interval check into one compare.
   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return (a - ADDR_BEGIN) <= (ADDR_END - ADDR_BEGIN);
   endfunction

   logic [NUM_RESV-1:0] valid_q, valid_d, install, inval;
   logic [NUM_RESV-1:0] lr_id_hit, sc_id_hit, sc_gran_hit, wr_gran_hit;
   logic [GW-1:0]       lr_gran, sc_gran, wr_gran;
   logic [VW-1:0]       victim_q, free_idx;
   logic                free_found, evict;
   logic                sc_fire, sc_ok, wr_act, lr_act;
   logic [OW-1:0]       occ_d;

   assign lr_gran    = lr_addr_i[ADDR_WIDTH-1:ADDR_LSB];
   assign sc_gran    = sc_addr_i[ADDR_WIDTH-1:ADDR_LSB];
   assign wr_gran    = wr_addr_i[ADDR_WIDTH-1:ADDR_LSB];

   assign sc_ready_o = !sc_resp_valid_o || sc_resp_ready_i;
   assign sc_fire    = sc_valid_i && sc_ready_o;
   assign sc_ok      = in_range(sc_addr_i) && |(sc_id_hit & sc_gran_hit);
   assign wr_act     = wr_valid_i && in_range(wr_addr_i);
   // A same-granule snooped write suppresses the LR entirely.
   assign lr_act     = lr_valid_i && in_range(lr_addr_i) && !(wr_act && (wr_gran == lr_gran));

   assign inval = (sc_fire ? (sc_id_hit | (sc_ok ? sc_gran_hit : '0)) : '0)
                | (wr_act ? wr_gran_hit : '0);

   always_comb begin
      install    = '0;
      free_idx   = '0;
      free_found = 1'b0;
      evict      = 1'b0;
      for (int i = 0; i < NUM_RESV; i++) begin
         if (!valid_q[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = VW'(i);
         end
      end
      if (lr_act) begin
         if (|lr_id_hit)      install = lr_id_hit;
         else if (free_found) install[free_idx] = 1'b1;
         else begin
            install[victim_q] = 1'b1;
            evict             = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_RESV; g++) begin : g_entry
      axi_riscv_lrsc_resv_entry #(
         .ID_WIDTH     (ID_WIDTH),
         .GRAN_WIDTH   (GW),
         .RESV_TIMEOUT (RESV_TIMEOUT)
      ) u_entry (
         .clk_i         (clk_i),
         .rst_ni        (rst_ni),
         .install_i     (install[g]),
         .invalidate_i  (inval[g]),
         .id_i          (lr_id_i),
         .gran_i        (lr_gran),
         .sc_id_i       (sc_id_i),
         .sc_gran_i     (sc_gran),
         .wr_gran_i     (wr_gran),
         .valid_o       (valid_q[g]),
         .valid_d_o     (valid_d[g]),
         .lr_id_hit_o   (lr_id_hit[g]),
         .sc_id_hit_o   (sc_id_hit[g]),
         .sc_gran_hit_o (sc_gran_hit[g]),
         .wr_gran_hit_o (wr_gran_hit[g])
      );
   end

   always_comb begin
      occ_d = '0;
      for (int i = 0; i < NUM_RESV; i++) occ_d = occ_d + OW'(valid_d[i]);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         victim_q        <= '0;
         occupancy_o     <= '0;
         sc_resp_valid_o <= 1'b0;
         sc_resp_ok_o    <= 1'b0;
         sc_resp_id_o    <= '0;
      end else begin
         occupancy_o <= occ_d;
         if (evict) victim_q <= (victim_q == VW'(NUM_RESV - 1)) ? '0 : victim_q + 1'b1;
         if (sc_fire) begin
            sc_resp_valid_o <= 1'b1;
            sc_resp_ok_o    <= sc_ok;
            sc_resp_id_o    <= sc_id_i;
         end else if (sc_resp_ready_i) begin
            sc_resp_valid_o <= 1'b0;
         end
      end
   end

endmodule
